g20_slave_resp: RTL and testbench

Bus-side responder for the g20 arbitrated bus: the slave end that sits behind the arbiter's slave port. It decodes the address the arbiter forwards, owns a small word-addressed register window, and performs burst writes (capturing `dataIn`) or burst reads (driving `dbus_out`) until the arbiter signals transfer end on `Xend`. One instance per slave window; several instances share the arbiter's slave signals, with non-selected instances driving zero.

---
 rtl/g20_pkg.sv | 17 +
 rtl/g20_slave_regfile.sv | 36 +++
 rtl/g20_slave_resp.sv | 144 ++++++++++++++
 tb/tb_g20_slave_resp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/g20_pkg.sv
// rtl/g20_pkg.sv - shared types and constants for the g20 bus slave responder
// Purpose: bus widths, write-direction bit position and the slave FSM state type.
// Ports: none (package).
package g20_pkg;

    localparam int G20_ADDR_W = 48;
    localparam int G20_DATA_W = 16;
    localparam int G20_WR_BIT = 47;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_RD    = 2'd2,
        S_DRAIN = 2'd3
    } g20_slv_state_t;

endpackage

// File: rtl/g20_slave_regfile.sv
// rtl/g20_slave_regfile.sv - DEPTH x DATA_W register window storage
// Purpose: word storage cleared by synchronous reset, one write port, one
//          combinational read port (the caller registers the read data).
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset (clears every word)
//   i_we/i_waddr/i_wdata  write port
//   i_raddr/o_rdata   read port
module g20_slave_regfile #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Reset has priority so a write beat coinciding with reset is lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/g20_slave_resp.sv
// rtl/g20_slave_resp.sv - g20 arbitrated-bus slave: window decode and burst read/write
// Purpose: decodes the forwarded address against [BASE_ADDR, BASE_ADDR+DEPTH),
//          runs write bursts into the window or read bursts onto dbus_out
//          until Xend. Optional macro G20_SLAVE_WRAP_EN makes the burst
//          pointer wrap inside the window; without it the pointer saturates
//          and further beats are dropped (writes) or read as zero.
// Ports:
//   Qclock, BusReset  bus clock, synchronous active-high reset
//   Adr               [47] write/read, [46:0] word address (start cycle)
//   dataIn            write data, one word per beat
//   select_slave      transfer in progress
//   Xend              final beat marker
//   dbus_out          registered read data, zero outside read beats
module g20_slave_resp
    import g20_pkg::*;
#(
    parameter logic [G20_ADDR_W-2:0] BASE_ADDR = 47'h0000_1000,
    parameter int                    DEPTH     = 16,
    parameter int                    DATA_W    = G20_DATA_W
) (
    input  logic                  Qclock,
    input  logic                  BusReset,
    input  logic [G20_ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0]     dataIn,
    input  logic                  select_slave,
    input  logic                  Xend,
    output logic [DATA_W-1:0]     dbus_out
);

    localparam int PTR_W = $clog2(DEPTH);

    g20_slv_state_t        r_state, w_state_nxt;
    logic [PTR_W-1:0]      r_ptr, w_ptr_nxt, w_ptr_inc, w_raddr;
    logic                  r_ovf, w_ovf_nxt, w_step_ovf;
    logic [DATA_W-1:0]     r_dout, w_dout_nxt, w_rdata;
    logic [G20_ADDR_W-2:0] w_offset;
    logic                  w_hit, w_is_wr, w_we;

    // Addresses below BASE_ADDR underflow to huge offsets and so miss.
    assign w_offset = Adr[G20_ADDR_W-2:0] - BASE_ADDR;
    assign w_hit    = (w_offset < (G20_ADDR_W-1)'(DEPTH));
    assign w_is_wr  = Adr[G20_WR_BIT];

`ifdef G20_SLAVE_WRAP_EN
    assign w_ptr_inc  = r_ptr + PTR_W'(1);
    assign w_step_ovf = 1'b0;
`else
    logic w_ptr_end;
    assign w_ptr_end  = (r_ptr == PTR_W'(DEPTH - 1));
    assign w_ptr_inc  = w_ptr_end ? r_ptr : r_ptr + PTR_W'(1);
    assign w_step_ovf = w_ptr_end;
`endif

    // IDLE looks up the start word; RD prefetches the next word.
    assign w_raddr = (r_state == S_IDLE) ? w_offset[PTR_W-1:0] : w_ptr_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_ovf_nxt   = r_ovf;
        w_dout_nxt  = '0;
        w_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ovf_nxt = 1'b0;
                if (select_slave) begin
                    if (Xend || !w_hit) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_ptr_nxt = w_offset[PTR_W-1:0];
                        if (w_is_wr) begin
                            w_state_nxt = S_WR;
                        end else begin
                            w_state_nxt = S_RD;
                            w_dout_nxt  = w_rdata;
                        end
                    end
                end
            end
            S_WR: begin
                if (!select_slave) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_we      = !r_ovf;
                    w_ptr_nxt = w_ptr_inc;
                    w_ovf_nxt = r_ovf | w_step_ovf;
                    // Leave through DRAIN so a still-high select cannot restart.
                    if (Xend) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_RD: begin
                if (!select_slave) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ptr_nxt = w_ptr_inc;
                    w_ovf_nxt = r_ovf | w_step_ovf;
                    if (Xend) begin
                        w_state_nxt = S_DRAIN;
                    end else if (!(r_ovf || w_step_ovf)) begin
                        w_dout_nxt = w_rdata;
                    end
                end
            end
            S_DRAIN: begin
                if (!select_slave) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Qclock) begin
        if (BusReset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_ovf   <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ovf   <= w_ovf_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    g20_slave_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_regfile (
        .i_clk   (Qclock),
        .i_rst   (BusReset),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata (dataIn),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign dbus_out = r_dout;

endmodule

// File: tb/tb_g20_slave_resp.sv
// tb/tb_g20_slave_resp.sv - directed self-checking bench for g20_slave_resp
module tb_g20_slave_resp;

`ifdef G20_SLAVE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        Qclock = 1'b0;
    logic        BusReset;
    logic [47:0] Adr;
    logic [15:0] dataIn;
    logic        select_slave;
    logic        Xend;
    logic [15:0] dbus_out;

    logic [15:0] exp_v [4];
    int          n_checks = 0;
    int          n_errors = 0;

    g20_slave_resp dut (
        .Qclock       (Qclock),
        .BusReset     (BusReset),
        .Adr          (Adr),
        .dataIn       (dataIn),
        .select_slave (select_slave),
        .Xend         (Xend),
        .dbus_out     (dbus_out)
    );

    always #5 Qclock = ~Qclock;

    task automatic tick();
        @(posedge Qclock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Read burst of n beats; expected words come from exp_v.
    task automatic rd_burst(input string tag, input logic [46:0] a, input int n);
        select_slave = 1'b1;
        Adr          = {1'b0, a};
        Xend         = 1'b0;
        dataIn       = 16'h0000;
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq($sformatf("%s_b%0d", tag, i), dbus_out, exp_v[i]);
            if (i == n - 1) Xend = 1'b1;
        end
        tick();
        check_eq($sformatf("%s_end", tag), dbus_out, 16'h0000);
        select_slave = 1'b0;
        Xend         = 1'b0;
        tick();
    endtask

    // Two-beat write burst, then hold select high with a read of the same
    // address: a responder that failed to drain would restart and show d0.
    task automatic wr2(input string tag, input logic [46:0] a, input logic [15:0] d0, input logic [15:0] d1);
        select_slave = 1'b1;
        Adr          = {1'b1, a};
        Xend         = 1'b0;
        dataIn       = 16'h0000;
        tick();
        dataIn = d0;
        tick();
        dataIn = d1;
        Xend   = 1'b1;
        tick();
        Xend   = 1'b0;
        Adr    = {1'b0, a};
        tick();
        check_eq($sformatf("%s_drain", tag), dbus_out, 16'h0000);
        select_slave = 1'b0;
        tick();
    endtask

    initial begin
        logic [46:0] miss_a [3];
        miss_a = '{47'h2000, 47'h0FFF, 47'h1010};

        // Reset with a write transfer pending at offset 0.
        BusReset     = 1'b1;
        select_slave = 1'b1;
        Adr          = 48'h8000_0000_1000;
        dataIn       = 16'hDEAD;
        Xend         = 1'b0;
        tick();
        tick();
        check_eq("rst_dbus", dbus_out, 16'h0000);
        BusReset     = 1'b0;
        select_slave = 1'b0;
        tick();
        check_eq("rst_idle_dbus", dbus_out, 16'h0000);
        exp_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rd_burst("rst_mem", 47'h1000, 2);

        wr2("wr_a5", 47'h1002, 16'hA5A5, 16'h5A5A);
        exp_v = '{16'hA5A5, 16'h5A5A, 16'h0000, 16'h0000};
        rd_burst("rd_a5", 47'h1002, 3);

        // Misses: far away, just below the window, one past its end.
        for (int i = 0; i < 3; i++) begin
            select_slave = 1'b1;
            Adr          = {1'b1, miss_a[i]};
            dataIn       = 16'hFFFF;
            Xend         = 1'b0;
            tick();
            check_eq($sformatf("miss%0d_b0", i), dbus_out, 16'h0000);
            tick();
            Xend = 1'b1;
            tick();
            check_eq($sformatf("miss%0d_end", i), dbus_out, 16'h0000);
            select_slave = 1'b0;
            Xend         = 1'b0;
            tick();
        end
        exp_v = '{16'h0000, 16'h0000, 16'hA5A5, 16'h5A5A};
        rd_burst("miss_mem", 47'h1000, 4);

        // Burst across the window end.
        wr2("wr_end", 47'h100F, 16'h1111, 16'h2222);
        exp_v = '{16'h1111, WRAP ? 16'h2222 : 16'h0000, 16'h0000, 16'h0000};
        rd_burst("rd_end", 47'h100F, 2);
        exp_v = '{WRAP ? 16'h2222 : 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rd_burst("rd_m0", 47'h1000, 1);
        exp_v = '{16'h1111, 16'h0000, 16'h0000, 16'h0000};
        rd_burst("rd_m15", 47'h100F, 1);

        // Read aborted by select dropping, restarted the following cycle.
        wr2("wr_beef", 47'h1000, 16'hBEEF, 16'hCAFE);
        select_slave = 1'b1;
        Adr          = 48'h0000_0000_1002;
        Xend         = 1'b0;
        tick();
        check_eq("abort_b0", dbus_out, 16'hA5A5);
        select_slave = 1'b0;
        tick();
        check_eq("abort_zero", dbus_out, 16'h0000);
        select_slave = 1'b1;
        Adr          = 48'h0000_0000_1000;
        tick();
        check_eq("restart_b0", dbus_out, 16'hBEEF);
        tick();
        check_eq("restart_b1", dbus_out, 16'hCAFE);
        Xend = 1'b1;
        tick();
        check_eq("restart_end", dbus_out, 16'h0000);
        select_slave = 1'b0;
        Xend         = 1'b0;
        tick();

        // Reset in the middle of a write burst.
        select_slave = 1'b1;
        Adr          = 48'h8000_0000_1004;
        tick();
        dataIn = 16'h1234;
        tick();
        dataIn   = 16'h5678;
        BusReset = 1'b1;
        tick();
        check_eq("rstw_dbus", dbus_out, 16'h0000);
        BusReset     = 1'b0;
        select_slave = 1'b0;
        tick();
        exp_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rd_burst("rstw_mem", 47'h1004, 2);
        exp_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        rd_burst("rstw_m2", 47'h1002, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
